// File: rtl/dp_pkg.sv
// dp_pkg: shared width default and bus-source selection for the datapath
package dp_pkg;
  localparam int DP_WIDTH = 8;
  typedef enum logic [1:0] {SRC_Z, SRC_A, SRC_B, SRC_IMM} bus_src_e;
  // Fixed bus priority Z > A > B, falling back to the immediate when nothing drives.
  function automatic bus_src_e bus_sel(input logic zo, input logic ao, input logic bo);
    return zo ? SRC_Z : ao ? SRC_A : bo ? SRC_B : SRC_IMM;
  endfunction
endpackage

// File: rtl/dp_reg.sv
// dp_reg: W-bit register with synchronous active-low clear and load enable
//  i_clk     in  1  rising-edge clock
//  i_clear_n in  1  synchronous clear, active low, overrides load
//  i_load    in  1  load enable
//  i_d       in  W  data to load
//  o_q       out W  register contents
module dp_reg import dp_pkg::*; #(
  parameter int W = DP_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_clear_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  always_ff @(posedge i_clk)
    if (!i_clear_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/data_path.sv
// data_path: A/B/Z registers on one shared bus with an immediate adder feeding Z
//  clock              in  1     rising-edge clock
//  clear              in  1     synchronous clear, active low
//  AddImmediate       in  WIDTH addend for Z loads
//  RegisterAImmediate in  WIDTH bus value when no register drives
//  RZout/RAout/RBout  in  1     bus drive strobes, priority Z > A > B
//  RAin/RBin          in  1     load A/B from bus
//  RZin               in  1     load Z (and carry) from bus + AddImmediate
//  RA_q/RB_q/RZ_q     out WIDTH register contents
//  bus_q              out WIDTH combinational bus value
//  carry_q            out 1     carry of the last Z load
module data_path import dp_pkg::*; #(
  parameter int WIDTH = DP_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] AddImmediate,
  input  logic [WIDTH-1:0] RegisterAImmediate,
  input  logic             RZout,
  input  logic             RAout,
  input  logic             RBout,
  input  logic             RAin,
  input  logic             RBin,
  input  logic             RZin,
  output logic [WIDTH-1:0] RA_q,
  output logic [WIDTH-1:0] RB_q,
  output logic [WIDTH-1:0] RZ_q,
  output logic [WIDTH-1:0] bus_q,
  output logic             carry_q
);
  bus_src_e         w_src;
  logic [WIDTH-1:0] w_a, w_b, w_z, w_bus, w_sum;
  logic             w_carry;
  logic             r_carry;
  always_comb begin
    w_src = bus_sel(RZout, RAout, RBout);
    w_bus = (w_src == SRC_Z) ? w_z :
            (w_src == SRC_A) ? w_a :
            (w_src == SRC_B) ? w_b : RegisterAImmediate;
    {w_carry, w_sum} = {1'b0, w_bus} + {1'b0, AddImmediate};
  end
  dp_reg #(.W(WIDTH)) u_ra (.i_clk(clock), .i_clear_n(clear), .i_load(RAin), .i_d(w_bus), .o_q(w_a));
  dp_reg #(.W(WIDTH)) u_rb (.i_clk(clock), .i_clear_n(clear), .i_load(RBin), .i_d(w_bus), .o_q(w_b));
  dp_reg #(.W(WIDTH)) u_rz (.i_clk(clock), .i_clear_n(clear), .i_load(RZin), .i_d(w_sum), .o_q(w_z));
  always_ff @(posedge clock)
    if (!clear) r_carry <= 1'b0;
    else if (RZin) r_carry <= w_carry;
  assign RA_q    = w_a;
  assign RB_q    = w_b;
  assign RZ_q    = w_z;
  assign bus_q   = w_bus;
  assign carry_q = r_carry;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed scoreboard bench for data_path
module tb_data_path;
  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] add_imm = '0, reg_imm = '0;
  logic       rzo = 0, rao = 0, rbo = 0, rai = 0, rbi = 0, rzi = 0;
  logic [7:0] ra_q, rb_q, rz_q, bus_q;
  logic       carry_q;
  typedef struct {
    string      nm;
    logic [7:0] a, b, z, bus;
    logic       c;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  data_path dut (
    .clock(clk), .clear(clear), .AddImmediate(add_imm), .RegisterAImmediate(reg_imm),
    .RZout(rzo), .RAout(rao), .RBout(rbo), .RAin(rai), .RBin(rbi), .RZin(rzi),
    .RA_q(ra_q), .RB_q(rb_q), .RZ_q(rz_q), .bus_q(bus_q), .carry_q(carry_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input string f, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s got %h want %h", nm, f, act, exp);
    end
  endtask
  task automatic step(input string nm, input logic clr, input logic [7:0] ai, input logic [7:0] ri,
                      input logic zo, input logic ao, input logic bo,
                      input logic ain, input logic bin, input logic zin,
                      input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ez,
                      input logic [7:0] ebus, input logic ec);
    @(negedge clk);
    clear = clr; add_imm = ai; reg_imm = ri;
    rzo = zo; rao = ao; rbo = bo; rai = ain; rbi = bin; rzi = zin;
    @(posedge clk);
    q.push_back('{nm, ea, eb, ez, ebus, ec});
  endtask
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.nm, "A", ra_q, e.a);
      chk(e.nm, "B", rb_q, rb_q === e.b ? e.b : e.b);
      chk(e.nm, "Z", rz_q, e.z);
      chk(e.nm, "bus", bus_q, e.bus);
      chk(e.nm, "carry", {7'b0, carry_q}, {7'b0, e.c});
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    //    name          clr ai     ri     zo ao bo ai bi zi  A      B      Z      bus    c
    step("reset",       0, 8'hAA, 8'hAA, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 8'hAA, 0);
    step("ld_a",        1, 8'h00, 8'h05, 0, 0, 0, 1, 0, 0, 8'h05, 8'h00, 8'h00, 8'h05, 0);
    step("z_a_plus5",   1, 8'h05, 8'h00, 0, 1, 0, 0, 0, 1, 8'h05, 8'h00, 8'h0A, 8'h05, 0);
    step("b_from_z",    1, 8'h00, 8'h00, 1, 0, 0, 0, 1, 0, 8'h05, 8'h0A, 8'h0A, 8'h0A, 0);
    step("ld_a_ff",     1, 8'h00, 8'hFF, 0, 0, 0, 1, 0, 0, 8'hFF, 8'h0A, 8'h0A, 8'hFF, 0);
    step("z_wrap",      1, 8'h01, 8'h00, 0, 1, 0, 0, 0, 1, 8'hFF, 8'h0A, 8'h00, 8'hFF, 1);
    step("ld_a_05",     1, 8'h00, 8'h05, 0, 0, 0, 1, 0, 0, 8'h05, 8'h0A, 8'h00, 8'h05, 1);
    step("z_a_plus5b",  1, 8'h05, 8'h00, 0, 1, 0, 0, 0, 1, 8'h05, 8'h0A, 8'h0A, 8'h05, 0);
    step("prio_z",      1, 8'h00, 8'h00, 1, 1, 0, 0, 1, 0, 8'h05, 8'h0A, 8'h0A, 8'h0A, 0);
    step("prio_a",      1, 8'h01, 8'h00, 0, 1, 1, 0, 0, 1, 8'h05, 8'h0A, 8'h06, 8'h05, 0);
    step("self_a",      1, 8'h00, 8'h00, 0, 1, 0, 1, 0, 0, 8'h05, 8'h0A, 8'h06, 8'h05, 0);
    step("z_acc",       1, 8'h10, 8'h00, 1, 0, 0, 0, 0, 1, 8'h05, 8'h0A, 8'h16, 8'h16, 0);
    step("z_acc_carry", 1, 8'hF0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h05, 8'h0A, 8'h06, 8'h06, 1);
    step("b_only_bus",  1, 8'h00, 8'h00, 0, 0, 1, 1, 0, 0, 8'h0A, 8'h0A, 8'h06, 8'h0A, 1);
    step("multi_load",  1, 8'h01, 8'h3C, 0, 0, 0, 1, 1, 1, 8'h3C, 8'h3C, 8'h3D, 8'h3C, 0);
    step("idle_bus",    1, 8'h00, 8'h77, 0, 0, 0, 0, 0, 0, 8'h3C, 8'h3C, 8'h3D, 8'h77, 0);
    @(negedge clk);
    reg_imm = 8'h99; add_imm = 8'hFF; rao = 1; rai = 1; rbi = 1; rzi = 1;
    #3;
    reg_imm = 8'h42; add_imm = 8'h00; rao = 0; rai = 0; rbi = 0; rzi = 0;
    @(posedge clk);
    q.push_back('{"glitch", 8'h3C, 8'h3C, 8'h3D, 8'h42, 1'b0});
    step("mid_reset",   0, 8'h01, 8'h55, 0, 0, 0, 1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h55, 0);
    step("after_reset", 1, 8'h00, 8'h55, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
